jericalla_issuer: RTL

JERICALLA_ISSUER -- requirements
Module: jericalla_issuer

---
 rtl/jericalla_issuer.sv | 119 +++++++++++
 1 files changed

// File: rtl/jericalla_issuer.sv
// jericalla_issuer: instruction FIFO feeding a registered issue word.
// Each popped entry becomes {EN, dir1, dir2, op, dirR} on instr. EN is
// suppressed for conditional (skipz) entries when the preceding ALU result
// was zero, using the live ZF when the previous word was issued on the last
// edge and the remembered flag otherwise.
module jericalla_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_dir1,
    input  logic [3:0]                 req_dir2,
    input  logic [3:0]                 req_op,
    input  logic [3:0]                 req_dirR,
    input  logic                       req_we,
    input  logic                       req_skipz,
    input  logic                       halt,
    input  logic                       ZF,
    output logic [16:0]                instr,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                issued_cnt,
    output logic [7:0]                 skip_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    // Saturating increment for the skip counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Entry layout: {we, skipz, dir1, dir2, op, dirR}
    logic [17:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          zf_q;

    logic          push;
    logic          pop;
    logic [17:0]   head_p0;
    logic          zf_eff_p0;
    logic          skip_p0;
    logic          en_p0;

    // Ready comes from the registered level only, so a pop on the same edge
    // never opens room for a push into a full FIFO.
    assign req_ready = (level != LW'(DEPTH));
    assign push      = req_valid && req_ready;
    assign pop       = (level != '0) && !halt;

    // Issue-decision stage: head entry and effective zero flag.
    assign head_p0   = mem[rd_ptr];
    assign zf_eff_p0 = instr_valid ? ZF : zf_q;
    assign skip_p0   = head_p0[17] && head_p0[16] && zf_eff_p0;
    assign en_p0     = head_p0[17] && !(head_p0[16] && zf_eff_p0);

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_we, req_skipz, req_dir1, req_dir2, req_op, req_dirR};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Issue register: load head on pop, otherwise drop EN and keep fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr       <= '0;
            instr_valid <= 1'b0;
        end else if (pop) begin
            instr       <= {en_p0, head_p0[15:0]};
            instr_valid <= 1'b1;
        end else begin
            instr[16]   <= 1'b0;
            instr_valid <= 1'b0;
        end
    end

    // Remember the datapath zero flag for words issued after an idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q <= 1'b0;
        end else if (instr_valid) begin
            zf_q <= ZF;
        end
    end

    // Statistics: issued words wrap, suppressed writes saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
            skip_cnt   <= '0;
        end else if (pop) begin
            issued_cnt <= issued_cnt + 16'd1;
            if (skip_p0) skip_cnt <= sat_inc8(skip_cnt);
        end
    end

endmodule
